// File: rtl/xulie_pkg.sv
// Shared definitions for the serial sequence detector and its PISO feeder.
// Holds the one-hot state encodings and the default word/idle parameters.
// Both blocks import this package so the encodings cannot drift apart.
package xulie_pkg;

  // Default word length for the serial path.
  localparam int DEF_WIDTH = 8;

  // Line level while no word is being shifted; high keeps the detector unprimed.
  localparam logic DEF_IDLE_LEVEL = 1'b1;

  // One-hot shifter states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b01,
    S_SHIFT = 2'b10
  } state_t;

  // True only for the two legal one-hot codes.
  function automatic logic state_legal(input logic [1:0] s);
    return (s == S_IDLE) || (s == S_SHIFT);
  endfunction

endpackage

// File: rtl/xulie_hold_buf.sv
// One-deep word holding buffer with full flag between the load port and the shifter.
// Latency: a write is visible on data/full after one Clk edge.
// Backpressure: owner must not write while full; clr empties it regardless of strobes.
module xulie_hold_buf
  import xulie_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             wr,
  input  logic             rd,
  input  logic             clr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  // Full flag: clear wins, otherwise a read empties and a write fills.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      full <= 1'b0;
    end else if (clr) begin
      full <= 1'b0;
    end else begin
      full <= (full & ~rd) | wr;
    end
  end

  // Word storage: captured only on a write strobe.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      data <= '0;
    end else if (wr) begin
      data <= wr_data;
    end
  end

endmodule

// File: rtl/xulie_piso.sv
// Parallel-in/serial-out feeder for the sequence detector, one bit per Clk on Sout.
// Latency: word accepted at edge k while idle shows its first bit in the cycle after k.
// Backpressure: Ready = hold buffer empty; Load while Ready=0 is ignored.
module xulie_piso
  import xulie_pkg::*;
#(
  parameter int   WIDTH      = DEF_WIDTH,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] Data_in,
  output logic             Ready,
  output logic             Sout,
  output logic             Sout_valid,
  output logic             Busy,
  output logic             Word_done
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  // FSM state (kept as raw bits so illegal codes are representable and recoverable)
  logic [1:0]       state_q;
  logic [1:0]       state_nxt;

  // Bit counter and shift register
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_nxt;

  // Registered-output next values
  logic             sout_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  // Word sourcing
  logic             buf_full;
  logic [WIDTH-1:0] buf_data;
  logic             accept;
  logic             at_last;
  logic             need_word;
  logic             take_buf;
  logic             take_in;
  logic             load_word;
  logic             buf_wr;
  logic             buf_clr;
  logic [WIDTH-1:0] word_in;

  // Bit that goes on the line first for a freshly loaded or shifted register.
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Ready is a pure function of the buffer's full register: no path from Load.
  assign Ready   = ~buf_full;
  assign accept  = Load & Ready;

  // The shifter wants a new word when idle or when the last bit is on the line.
  assign at_last   = (state_q == S_SHIFT) && (cnt_q == LAST);
  assign need_word = (state_q == S_IDLE) || at_last;

  // Buffered word has priority over an incoming one so order is preserved.
  assign take_buf  = need_word & buf_full;
  assign take_in   = need_word & ~buf_full & accept;
  assign load_word = take_buf | take_in;
  assign word_in   = buf_full ? buf_data : Data_in;

  // Anything accepted but not bypassed straight into the shifter parks in the buffer.
  assign buf_wr  = accept & ~take_in;
  // A corrupted state code flushes the buffer along with the FSM recovery.
  assign buf_clr = ~state_legal(state_q);

  xulie_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold_buf (
    .Clk     (Clk),
    .Reset   (Reset),
    .wr      (buf_wr),
    .rd      (take_buf),
    .clr     (buf_clr),
    .wr_data (Data_in),
    .full    (buf_full),
    .data    (buf_data)
  );

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic: stay shifting across word boundaries when a word is ready.
  always_comb begin
    state_nxt = S_IDLE;
    case (state_q)
      S_IDLE: begin
        state_nxt = load_word ? S_SHIFT : S_IDLE;
      end
      S_SHIFT: begin
        if (at_last) begin
          state_nxt = load_word ? S_SHIFT : S_IDLE;
        end else begin
          state_nxt = S_SHIFT;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath next values: reload on a new word, else advance while shifting.
  always_comb begin
    cnt_nxt   = cnt_q;
    shreg_nxt = shreg_q;
    if (!state_legal(state_q)) begin
      cnt_nxt = '0;
    end else if (load_word) begin
      cnt_nxt   = '0;
      shreg_nxt = word_in;
    end else if ((state_q == S_SHIFT) && !at_last) begin
      cnt_nxt   = cnt_q + CW'(1);
      shreg_nxt = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
    end
  end

  // Output logic: next values for the registered line outputs.
  always_comb begin
    busy_nxt = (state_nxt == S_SHIFT);
    sout_nxt = busy_nxt ? lead_bit(shreg_nxt) : IDLE_LEVEL;
    done_nxt = busy_nxt && (cnt_nxt == LAST);
  end

  // Counter and shift register storage.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      cnt_q   <= cnt_nxt;
      shreg_q <= shreg_nxt;
    end
  end

  // Registered outputs so the detector sees glitch-free Din/valid.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Sout       <= IDLE_LEVEL;
      Sout_valid <= 1'b0;
      Busy       <= 1'b0;
      Word_done  <= 1'b0;
    end else begin
      Sout       <= sout_nxt;
      Sout_valid <= busy_nxt;
      Busy       <= busy_nxt;
      Word_done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_xulie_piso.sv
// Scoreboard bench for xulie_piso: an 8-bit MSB-first instance and a 4-bit LSB-first instance.
// Stimulus pushes hand-computed expected bits; negedge monitors pop and compare.
// Directed checks cover reset, Ready backpressure, mid-word reset and last-bit bypass.
module tb_xulie_piso;
  import xulie_pkg::*;

  typedef struct packed {
    logic b;
    logic done;
    logic cont;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Load = 1'b0;
  logic [7:0] Data_in = 8'h00;
  logic       Ready, Sout, Sout_valid, Busy, Word_done;

  logic       Load2 = 1'b0;
  logic [3:0] Data2 = 4'h0;
  logic       Ready2, Sout2, Sout_valid2, Busy2, Word_done2;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t q1[$];
  exp_t q2[$];
  logic prev1 = 1'b0;
  logic prev2 = 1'b0;
  logic [3:0] hist = 4'h0;
  logic seen_0111 = 1'b0;

  xulie_piso #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .Load(Load), .Data_in(Data_in),
    .Ready(Ready), .Sout(Sout), .Sout_valid(Sout_valid), .Busy(Busy), .Word_done(Word_done)
  );

  xulie_piso #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut4 (
    .Clk(Clk), .Reset(Reset), .Load(Load2), .Data_in(Data2),
    .Ready(Ready2), .Sout(Sout2), .Sout_valid(Sout_valid2), .Busy(Busy2), .Word_done(Word_done2)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // bits[n-1] is the first bit expected on the line; done marks each word's last bit.
  task automatic push_bits(input int which, input logic [15:0] bits, input int n,
                           input int width, input logic first_cont);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.b    = bits[n-1-i];
      e.done = ((i % width) == (width - 1));
      e.cont = (i == 0) ? first_cont : 1'b1;
      if (which == 1) q1.push_back(e);
      else            q2.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor for the 8-bit instance, plus a tiny 0111 detector on its stream.
  always @(negedge Clk) begin : mon1
    exp_t e;
    check("dut1_busy_eq_valid", Busy, Sout_valid);
    if (Sout_valid) begin
      if (q1.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL dut1_extra_bit: got bit %b expected no valid bit (t=%0t)", Sout, $time);
      end else begin
        e = q1.pop_front();
        check("dut1_bit", Sout, e.b);
        check("dut1_word_done", Word_done, e.done);
        if (e.cont) check("dut1_no_gap", prev1, 1'b1);
      end
      hist = {hist[2:0], Sout};
      if (hist == 4'b0111) seen_0111 = 1'b1;
    end else begin
      check("dut1_idle_sout", Sout, 1'b1);
      check("dut1_idle_done", Word_done, 1'b0);
    end
    prev1 = Sout_valid;
  end

  // Monitor for the 4-bit LSB-first instance.
  always @(negedge Clk) begin : mon2
    exp_t e;
    if (Sout_valid2) begin
      if (q2.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL dut4_extra_bit: got bit %b expected no valid bit (t=%0t)", Sout2, $time);
      end else begin
        e = q2.pop_front();
        check("dut4_bit", Sout2, e.b);
        check("dut4_word_done", Word_done2, e.done);
        if (e.cont) check("dut4_no_gap", prev2, 1'b1);
      end
    end else begin
      check("dut4_idle_sout", Sout2, 1'b1);
    end
    prev2 = Sout_valid2;
  end

  // Two back-to-back words, optionally with an FF pulse while Ready is low.
  task automatic run_pair(input logic inject_ff);
    push_bits(1, 16'b10100101_00111100, 16, 8, 1'b0);
    Load = 1'b1; Data_in = 8'hA5;
    tick();                                   // edge k: A5 straight into shifter
    Data_in = 8'h3C;
    tick();                                   // edge k+1: 3C into buffer
    Load = 1'b0;
    check("pair_ready_low_after_buffer", Ready, 1'b0);
    tick();                                   // k+2
    if (inject_ff) begin
      Load = 1'b1; Data_in = 8'hFF;
      tick();                                 // k+3: must be ignored
      Load = 1'b0;
    end else begin
      tick();
    end
    check("pair_ready_still_low", Ready, 1'b0);
    idle(4);                                  // k+7: last bit of A5 on line
    check("pair_ready_low_last_bit", Ready, 1'b0);
    tick();                                   // k+8: buffer drained into shifter
    check("pair_ready_high_after_drain", Ready, 1'b1);
    idle(12);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_ready", Ready, 1'b1);
    check("rst_sout", Sout, 1'b1);
    check("rst_valid", Sout_valid, 1'b0);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Word_done, 1'b0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    idle(2);

    // Single word 8'h70, one-cycle Load
    push_bits(1, 16'b01110000, 8, 8, 1'b0);
    Load = 1'b1; Data_in = 8'h70;
    tick();
    Load = 1'b0;
    check("w70_busy_after_load", Busy, 1'b1);
    idle(12);
    check("w70_sout_idle", Sout, 1'b1);
    check("w70_valid_idle", Sout_valid, 1'b0);
    check("w70_detector_saw_0111", seen_0111, 1'b1);

    // Back-to-back words, then again with an ignored FF pulse
    run_pair(1'b0);
    run_pair(1'b1);

    // Reset asserted while bit 3 of 8'h0F is on the line
    push_bits(1, 16'b0000, 4, 8, 1'b0);
    Load = 1'b1; Data_in = 8'h0F;
    tick();                                   // edge k: bit 0 on line
    Load = 1'b0;
    idle(3);                                  // bit 3 on line
    @(negedge Clk); #1;
    Reset = 1'b1;
    #1;
    check("midrst_sout_idle", Sout, 1'b1);
    check("midrst_valid_low", Sout_valid, 1'b0);
    check("midrst_ready_high", Ready, 1'b1);
    check("midrst_busy_low", Busy, 1'b0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    idle(15);
    check("midrst_no_more_bits", Sout_valid, 1'b0);

    // 4-bit LSB-first instance, 4'b1110 -> 0,1,1,1
    push_bits(2, 16'b0111, 4, 4, 1'b0);
    Load2 = 1'b1; Data2 = 4'b1110;
    tick();
    Load2 = 1'b0;
    idle(8);
    check("w4_sout_idle", Sout2, 1'b1);
    check("w4_ready", Ready2, 1'b1);

    // Load exactly on the last-bit cycle with an empty buffer: zero-gap bypass
    push_bits(1, 16'b10000001_01011010, 16, 8, 1'b0);
    Load = 1'b1; Data_in = 8'h81;
    tick();                                   // edge k
    Load = 1'b0;
    idle(7);                                  // last bit of 81 on line
    check("bypass_done_on_last", Word_done, 1'b1);
    Load = 1'b1; Data_in = 8'h5A;
    check("bypass_ready_before", Ready, 1'b1);
    tick();                                   // edge k+8: 5A bypasses
    Load = 1'b0;
    check("bypass_ready_after", Ready, 1'b1);
    check("bypass_busy", Busy, 1'b1);
    idle(12);

    // Every expected bit must have been consumed
    check("q1_drained", (q1.size() == 0), 1'b1);
    check("q2_drained", (q2.size() == 0), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
